// File: rtl/rom_line_fetcher.sv
// rom_line_fetcher
//
// Read-side client of a 128-bit program ROM. The ROM has a registered output,
// a one-cycle read latency and no read enable. This block walks line addresses
// sequentially and parks the returning lines in a 2-entry FIFO. From there the
// quad-issue decoder takes them over a valid/ready handshake.
//
// Handshake: a line transfers on a rising clk edge where line_valid and
// line_ready are both high. line_valid never depends combinationally on
// line_ready. While line_ready is low, line_valid, line_data, line_addr and
// line_mask hold their values until the transfer happens or a redirect
// flushes the buffer.
//
// Optional build macro: FETCH_PERF_EN adds the perf_lines and perf_bubbles
// counters. When the macro is undefined those ports and registers are not
// present.
//
// Ports:
//   clk            - single clock, shared with the ROM read port
//   reset_n        - asynchronous active-low reset, synchronous release
//   rom_addr       - ROM line address; the ROM samples it on every posedge
//   rom_dout       - ROM data for the address sampled at the previous edge
//   redirect_valid - single-cycle branch/exception redirect strobe
//   redirect_addr  - target instruction address: line in [ADDR_WIDTH+1:2],
//                    lane in [1:0]
//   line_valid     - buffer head holds a line
//   line_ready     - decoder accepts the head line
//   line_data      - head line (lane 0 = bits 31:0), zero when not valid
//   line_addr      - ROM line address of the head line, zero when not valid
//   line_mask      - valid lanes of the head line, zero when not valid
//   perf_lines     - (FETCH_PERF_EN) count of lines handed to the decoder
//   perf_bubbles   - (FETCH_PERF_EN) count of cycles the decoder was ready
//                    but no line was available
module rom_line_fetcher #(
    parameter int ADDR_WIDTH = 13,
    parameter int LINE_WIDTH = 128,
    parameter int LANES      = 4,
    parameter int RESET_LINE = 0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    output logic [ADDR_WIDTH-1:0]   rom_addr,
    input  logic [LINE_WIDTH-1:0]   rom_dout,
    input  logic                    redirect_valid,
    input  logic [ADDR_WIDTH+1:0]   redirect_addr,
    output logic                    line_valid,
    input  logic                    line_ready,
    output logic [LINE_WIDTH-1:0]   line_data,
    output logic [ADDR_WIDTH-1:0]   line_addr,
    output logic [LANES-1:0]        line_mask
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]             perf_lines,
    output logic [31:0]             perf_bubbles
`endif
);

    localparam logic [ADDR_WIDTH-1:0] RESET_PTR = ADDR_WIDTH'(RESET_LINE);

    // Fetch pointer and the address of the request currently inside the ROM.
    logic [ADDR_WIDTH-1:0] fetch_ptr_q, fetch_ptr_d;
    logic [ADDR_WIDTH-1:0] req_addr_q,  req_addr_d;
    logic                  inflight_q,  inflight_d;

    // Two-entry line buffer.
    logic [LINE_WIDTH-1:0] buf_data_q [2];
    logic [LINE_WIDTH-1:0] buf_data_d [2];
    logic [ADDR_WIDTH-1:0] buf_addr_q [2];
    logic [ADDR_WIDTH-1:0] buf_addr_d [2];
    logic [LANES-1:0]      buf_mask_q [2];
    logic [LANES-1:0]      buf_mask_d [2];
    logic [1:0]            count_q,  count_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic                  wr_ptr_q, wr_ptr_d;

    // First-line lane mask armed by a redirect, consumed by the next push.
    logic                  pend_valid_q, pend_valid_d;
    logic [LANES-1:0]      pend_mask_q,  pend_mask_d;

    logic                  pop;
    logic                  push;
    logic                  issue;
    logic [2:0]            occupancy;
    logic [LANES-1:0]      redirect_mask;
    logic [LANES-1:0]      all_lanes;

`ifdef FETCH_PERF_EN
    logic [31:0]           perf_lines_q,   perf_lines_d;
    logic [31:0]           perf_bubbles_q, perf_bubbles_d;
`endif

    // Outputs are forced to zero while the buffer is empty. Entries left over
    // after a flush therefore never show through.
    always_comb begin
        line_valid = (count_q != 2'd0);
        line_data  = line_valid ? buf_data_q[rd_ptr_q] : '0;
        line_addr  = line_valid ? buf_addr_q[rd_ptr_q] : '0;
        line_mask  = line_valid ? buf_mask_q[rd_ptr_q] : '0;
        rom_addr   = fetch_ptr_q;
    end

    always_comb begin
        all_lanes     = '1;
        // Lanes below the target lane are cleared; lane 2 gives 4'b1100.
        redirect_mask = all_lanes << redirect_addr[1:0];

        pop       = line_valid && line_ready;
        occupancy = {1'b0, count_q} + {2'b00, inflight_q};
        // A request is only sent when a buffer slot is guaranteed for its
        // data. Every line already in the buffer or still in the ROM holds one
        // of the two slots. A pop on this same edge frees one slot.
        issue     = !redirect_valid &&
                    ((occupancy < 3'd2) || ((occupancy == 3'd2) && pop));
        // A redirect cancels whatever the ROM is returning this edge.
        push      = inflight_q && !redirect_valid;

        fetch_ptr_d  = fetch_ptr_q;
        req_addr_d   = req_addr_q;
        inflight_d   = inflight_q;
        buf_data_d   = buf_data_q;
        buf_addr_d   = buf_addr_q;
        buf_mask_d   = buf_mask_q;
        count_d      = count_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        pend_valid_d = pend_valid_q;
        pend_mask_d  = pend_mask_q;

        if (redirect_valid) begin
            // Flush. A pop on this edge still completes. The decoder already
            // owns that line, so dropping the whole buffer is correct.
            count_d      = 2'd0;
            rd_ptr_d     = 1'b0;
            wr_ptr_d     = 1'b0;
            inflight_d   = 1'b0;
            fetch_ptr_d  = redirect_addr[ADDR_WIDTH+1:2];
            pend_valid_d = 1'b1;
            pend_mask_d  = redirect_mask;
        end else begin
            inflight_d = issue;
            if (issue) begin
                req_addr_d  = fetch_ptr_q;
                fetch_ptr_d = fetch_ptr_q + ADDR_WIDTH'(1);
            end
            if (push) begin
                buf_data_d[wr_ptr_q] = rom_dout;
                buf_addr_d[wr_ptr_q] = req_addr_q;
                buf_mask_d[wr_ptr_q] = pend_valid_q ? pend_mask_q : all_lanes;
                pend_valid_d         = 1'b0;
                wr_ptr_d             = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_ptr_q  <= RESET_PTR;
            req_addr_q   <= '0;
            inflight_q   <= 1'b0;
            count_q      <= 2'd0;
            rd_ptr_q     <= 1'b0;
            wr_ptr_q     <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_mask_q  <= '0;
            for (int i = 0; i < 2; i++) begin
                buf_data_q[i] <= '0;
                buf_addr_q[i] <= '0;
                buf_mask_q[i] <= '0;
            end
        end else begin
            fetch_ptr_q  <= fetch_ptr_d;
            req_addr_q   <= req_addr_d;
            inflight_q   <= inflight_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            pend_valid_q <= pend_valid_d;
            pend_mask_q  <= pend_mask_d;
            for (int i = 0; i < 2; i++) begin
                buf_data_q[i] <= buf_data_d[i];
                buf_addr_q[i] <= buf_addr_d[i];
                buf_mask_q[i] <= buf_mask_d[i];
            end
        end
    end

`ifdef FETCH_PERF_EN
    // Redirects do not clear these counters; only reset does.
    always_comb begin
        perf_lines_d   = perf_lines_q;
        perf_bubbles_d = perf_bubbles_q;
        if (pop) begin
            perf_lines_d = perf_lines_q + 32'd1;
        end
        if (line_ready && !line_valid) begin
            perf_bubbles_d = perf_bubbles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_lines_q   <= '0;
            perf_bubbles_q <= '0;
        end else begin
            perf_lines_q   <= perf_lines_d;
            perf_bubbles_q <= perf_bubbles_d;
        end
    end

    assign perf_lines   = perf_lines_q;
    assign perf_bubbles = perf_bubbles_q;
`endif

endmodule

// File: tb/tb_rom_line_fetcher.sv
module tb_rom_line_fetcher;

    localparam int AW    = 13;
    localparam int LW    = 128;
    localparam int LANES = 4;
    localparam int NUM_LINES = 8192;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [AW-1:0]     rom_addr;
    logic [LW-1:0]     rom_dout;
    logic              redirect_valid;
    logic [AW+1:0]     redirect_addr;
    logic              line_valid;
    logic              line_ready;
    logic [LW-1:0]     line_data;
    logic [AW-1:0]     line_addr;
    logic [LANES-1:0]  line_mask;
`ifdef FETCH_PERF_EN
    logic [31:0]       perf_lines;
    logic [31:0]       perf_bubbles;
`endif

    int vectors = 0;
    int miscompares = 0;

    // Reference model: the delivered stream is sequential from the most recent
    // redirect target (or the reset line). Only the first line after a
    // redirect has lanes below the target lane removed.
    int          exp_next;
    logic [3:0]  exp_mask;
    int          m_lines;
    int          m_bubbles;

    rom_line_fetcher #(
        .ADDR_WIDTH (AW),
        .LINE_WIDTH (LW),
        .LANES      (LANES),
        .RESET_LINE (0)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .rom_addr       (rom_addr),
        .rom_dout       (rom_dout),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .line_valid     (line_valid),
        .line_ready     (line_ready),
        .line_data      (line_data),
        .line_addr      (line_addr),
        .line_mask      (line_mask)
`ifdef FETCH_PERF_EN
        ,
        .perf_lines     (perf_lines),
        .perf_bubbles   (perf_bubbles)
`endif
    );

    // Clock and ROM model: line k holds the value k, with one cycle of
    // registered latency.
    always #5 clk = ~clk;

    always @(posedge clk) begin
        rom_dout <= {{(LW-AW){1'b0}}, rom_addr};
    end

    task automatic model_reset();
        exp_next  = 0;
        exp_mask  = 4'hF;
        m_lines   = 0;
        m_bubbles = 0;
    endtask

    // Called at a negedge. It drives the inputs for the next posedge and
    // checks any line that will transfer on that edge. It then advances to
    // the following negedge.
    task automatic step(input logic rdy, input logic redir, input logic [AW+1:0] raddr);
        logic [LW-1:0] exp_data;
        int lane;
        line_ready     = rdy;
        redirect_valid = redir;
        redirect_addr  = raddr;
        if (line_valid && rdy) begin
            exp_data = '0;
            exp_data[AW-1:0] = exp_next[AW-1:0];
            vectors++;
            if (line_addr !== exp_next[AW-1:0] || line_mask !== exp_mask || line_data !== exp_data) begin
                miscompares++;
                $display("FAIL pop_line: got addr=%h mask=%b data=%h required addr=%h mask=%b data=%h",
                         line_addr, line_mask, line_data, exp_next[AW-1:0], exp_mask, exp_data);
            end
            exp_next = (exp_next + 1) % NUM_LINES;
            exp_mask = 4'hF;
            m_lines++;
        end
        if (rdy && !line_valid) m_bubbles++;
        if (redir) begin
            exp_next = int'(raddr[AW+1:2]);
            lane = int'(raddr[1:0]);
            for (int i = 0; i < 4; i++) exp_mask[i] = (i >= lane);
        end
        @(posedge clk);
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    task automatic check_valid(input string name, input logic expv);
        vectors++;
        if (line_valid !== expv) begin
            miscompares++;
            $display("FAIL %s: got line_valid=%b required %b", name, line_valid, expv);
        end
    endtask

    // Verifies that the first redirected line appears after edge R+2 and not
    // earlier. Called at the negedge just after edge R.
    task automatic check_redirect_latency(input string name);
        check_valid({name, "_r0"}, 1'b0);
        step(1'b1, 1'b0, '0);
        check_valid({name, "_r1"}, 1'b0);
        step(1'b1, 1'b0, '0);
        check_valid({name, "_r2"}, 1'b1);
    endtask

    task automatic check_outputs_zero(input string name);
        vectors++;
        if (line_valid !== 1'b0 || line_data !== '0 || line_addr !== '0 ||
            line_mask !== '0 || rom_addr !== '0) begin
            miscompares++;
            $display("FAIL %s: got valid=%b data=%h addr=%h mask=%b rom_addr=%h required all zero",
                     name, line_valid, line_data, line_addr, line_mask, rom_addr);
        end
    endtask

    task automatic check_perf(input string name);
`ifdef FETCH_PERF_EN
        vectors++;
        if (perf_lines !== 32'(m_lines) || perf_bubbles !== 32'(m_bubbles)) begin
            miscompares++;
            $display("FAIL %s: got lines=%0d bubbles=%0d required lines=%0d bubbles=%0d",
                     name, perf_lines, perf_bubbles, m_lines, m_bubbles);
        end
`else
        name = name;
`endif
    endtask

    // Release reset at a negedge and check the 2-edge first-line latency.
    task automatic release_and_check_start(input string name);
        model_reset();
        reset_n = 1'b1;
        check_valid({name, "_e0"}, 1'b0);
        step(1'b1, 1'b0, '0);
        check_valid({name, "_e1"}, 1'b0);
        step(1'b1, 1'b0, '0);
        check_valid({name, "_e2"}, 1'b1);
    endtask

    task automatic test_reset();
        check_outputs_zero("reset_outputs");
        release_and_check_start("reset_latency");
        for (int i = 0; i < 4; i++) begin
            check_valid("steady_no_bubble", 1'b1);
            step(1'b1, 1'b0, '0);
        end
        check_perf("perf_after_reset");
    endtask

    task automatic test_stall();
        reset_n = 1'b0;
        line_ready = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        reset_n = 1'b1;
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (line_valid !== 1'b1 || line_data !== '0 || line_addr !== '0 || line_mask !== 4'hF) begin
                miscompares++;
                $display("FAIL stall_hold: got valid=%b data=%h addr=%h mask=%b required 1/0/0/f",
                         line_valid, line_data, line_addr, line_mask);
            end
            step(1'b0, 1'b0, '0);
        end
        for (int i = 0; i < 3; i++) begin
            check_valid("stall_release_b2b", 1'b1);
            step(1'b1, 1'b0, '0);
        end
        check_perf("perf_after_stall");
    endtask

    task automatic test_wrap();
        step(1'b1, 1'b1, 15'h7FFC);
        check_redirect_latency("wrap");
        for (int i = 0; i < 3; i++) begin
            check_valid("wrap_stream", 1'b1);
            step(1'b1, 1'b0, '0);
        end
    endtask

    task automatic test_redirect_full();
        repeat (3) step(1'b0, 1'b0, '0);
        vectors++;
        if (dut.count_q !== 2'd2) begin
            miscompares++;
            $display("FAIL buffer_full: got count=%0d required 2", dut.count_q);
        end
        step(1'b0, 1'b1, {13'h100, 2'd3});
        check_redirect_latency("redir_full");
        step(1'b1, 1'b0, '0);
        check_valid("redir_full_next", 1'b1);
        step(1'b1, 1'b0, '0);
    endtask

    task automatic test_redirect_pop();
        logic [AW+1:0] target;
        target = 15'($urandom_range(0, 32767));
        check_valid("redir_pop_head", 1'b1);
        step(1'b1, 1'b1, target);
        check_perf("perf_redir_pop");
        check_redirect_latency("redir_pop");
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
    endtask

    task automatic test_back_to_back();
        step(1'b1, 1'b1, 15'($urandom_range(0, 32767)));
        step(1'b1, 1'b1, 15'($urandom_range(0, 32767)));
        check_valid("b2b_redir_r0", 1'b0);
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        check_valid("b2b_redir_r2", 1'b1);
        repeat (3) step(1'b1, 1'b0, '0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
                 15'($urandom_range(0, 32767)));
        end
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        check_valid("random_recover", 1'b1);
        check_perf("perf_random");
    endtask

    task automatic test_reset_mid();
        check_valid("mid_stream", 1'b1);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_outputs_zero("mid_reset_outputs");
        @(negedge clk);
        @(negedge clk);
        release_and_check_start("mid_reset_restart");
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        check_perf("perf_mid_reset");
    endtask

    initial begin
        reset_n        = 1'b0;
        line_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        model_reset();
        repeat (3) @(negedge clk);
        test_reset();
        test_stall();
        test_wrap();
        test_redirect_full();
        test_redirect_pop();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rom_line_fetcher.md
Name: rom_line_fetcher

Overview:
- Read-side client of the 128-bit dual-port program ROM (8K lines, registered output, one-cycle read latency, no read enable).
- Generates sequential line addresses and absorbs the ROM latency with a 2-entry line buffer.
- Presents 128-bit instruction lines (four 32-bit lanes) to the quad-issue decoder over a valid/ready handshake.
- Supports branch redirect with flush and first-line lane masking.

Parameters:
- ADDR_WIDTH, 13, ROM line address width (8192 lines).
- LINE_WIDTH, 128, ROM line width in bits.
- LANES, 4, 32-bit instructions per line; lane 0 = bits 31:0.
- RESET_LINE, 0, first line fetched after reset.

Ports:
- clk  in  1  single clock; also drives the ROM port used.
- reset_n  in  1  asynchronous active-low reset.
- rom_addr  out  ADDR_WIDTH  ROM address; the ROM samples it on every posedge.
- rom_dout  in  LINE_WIDTH  ROM registered data for the address sampled at the previous edge.
- redirect_valid  in  1  single-cycle branch/exception redirect strobe.
- redirect_addr  in  ADDR_WIDTH+2  target instruction address; [ADDR_WIDTH+1:2] = line, [1:0] = lane.
- line_valid  out  1  buffer head holds a line.
- line_ready  in  1  decoder accepts the head line.
- line_data  out  LINE_WIDTH  head line.
- line_addr  out  ADDR_WIDTH  ROM line address of the head line.
- line_mask  out  LANES  valid lanes of the head line.

Behaviour:
- Reset (async assert, sync release): buffer empty, in-flight flag 0, fetch_ptr = RESET_LINE. line_valid = 0; line_data, line_addr and line_mask = 0. rom_addr = fetch_ptr.
- rom_addr is driven from fetch_ptr. An edge with issue = 1 sends a request; the in-flight flag is then set for the next cycle.
- issue = !redirect_valid && ((count + inflight < 2) || (count + inflight == 2 && pop)).
  - pop = line_valid && line_ready.
  - On issue, fetch_ptr increments, wrapping from 8191 to 0.
- Return path: if inflight is set, rom_dout is written into the buffer tail at the next edge, with its line address and mask. Credits guarantee the buffer never overflows.
- Buffer ordering is FIFO. Push and pop on the same edge are allowed; count is unchanged.
- Latency:
  - First line: line_valid is high after the 2nd posedge following reset release.
  - Steady state: with line_ready held high, one line per cycle with no bubbles.
- Masks:
  - Sequential lines have line_mask = 4'hF.
  - The first line after a redirect has lanes below redirect_addr[1:0] cleared (e.g. lane 2 gives 4'b1100).
- Redirect at edge R:
  - The buffer is flushed and inflight is cleared. Any rom_dout returning after R for a pre-redirect request is discarded.
  - fetch_ptr is loaded with the redirect line; no issue occurs at R.
  - The first redirected line is valid after edge R+2.
  - A pending first-line mask is armed and is applied to the next pushed line only.
- Simultaneous redirect and pop at the same edge: the pop completes (the decoder owns that line) and the flush applies to the rest. Redirect outranks push.
- Back-to-back redirects: the most recent one wins and the previous target is never delivered.
- line_ready low: the head and all outputs stay stable. rom_addr may change, but no un-credited request is ever issued.
- Reset mid-operation returns to the reset state immediately. Any in-flight ROM data is ignored.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined, two outputs are added:
  - perf_lines [31:0]: increments on each pop.
  - perf_bubbles [31:0]: increments each cycle with line_ready = 1 and line_valid = 0.
- Both counters are cleared by reset, wrap modulo 2^32, and are not cleared by redirect.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- Reset release, line_ready = 1, ROM line k = k: line_valid rises after edge 2; line_addr reads 0,1,2,3 on consecutive cycles; mask is 4'hF throughout.
- Hold line_ready = 0 for 10 cycles after the first line: line_data = 0 remains stable. On release, lines 0,1,2 arrive back-to-back; no line is lost or duplicated.
- Start fetch_ptr near the end via redirect to address 0x7FFC (line 8191, lane 0): lines delivered are 8191 then 0 then 1.
- Redirect to line 0x100, lane 3, while the buffer is full: stale lines never appear. After R+2: line_addr = 0x100 with mask 4'b1000, then 0x101 with mask 4'hF.
- Redirect on the same edge as a pop: the popped line is counted consumed. The next delivered line is the redirect target. With FETCH_PERF_EN, perf_lines is incremented exactly once for that edge.
- Assert reset_n low mid-stream with inflight = 1: outputs drop to 0 immediately. After release, fetch restarts at RESET_LINE with 2-cycle latency.
